// File: rtl/snn_ctrl_pkg.sv
// Shared types and defaults for the spiking-neuron event scheduler.
// Holds the scheduler state encoding and a width helper.
package snn_ctrl_pkg;

  localparam int N_IN_DEF       = 8;
  localparam int ADDR_W_DEF     = 3;
  localparam int REFRACTORY_DEF = 50000;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting line
// at or after ptr, wrapping from N_IN-1 back to 0.
module rr_arbiter
  import snn_ctrl_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [N_IN-1:0]   req,
  input  logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] gnt_idx,
  output logic              gnt_valid
);

  always_comb begin
    int s;
    logic [ADDR_W-1:0] idx;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    s         = 0;
    idx       = '0;
    // Walk from the farthest offset so the nearest hit wins.
    for (int k = N_IN - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= N_IN) s = s - N_IN;
      idx = ADDR_W'(s);
      if (req[idx]) begin
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_event_scheduler.sv
// Arbitrates presynaptic spike requests into weight-ROM reads
// and applies a refractory window after each output spike.
module spike_event_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int REFRACTORY = REFRACTORY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_IN-1:0]   spikes_in,
  output logic [N_IN-1:0]   acks_out,
  input  logic              fire,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic              acc_en,
  output logic              acc_clear,
  output logic              spike_out,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [CNT_W-1:0] REFR_LOAD = CNT_W'(REFRACTORY);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_IN - 1);

  sched_state_e      state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] grant_idx;
  logic [ADDR_W-1:0] arb_idx;
  logic              arb_valid;
  logic [CNT_W-1:0]  refr_cnt;
  logic [CNT_W-1:0]  refr_nxt;
  logic              fire_ok;
  logic              suppress;

  rr_arbiter #(
    .N_IN   (N_IN),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .req       (spikes_in),
    .ptr       (ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Outputs are registered, so judge the ISSUE cycle by
  // the refractory and clear state it will actually see.
  always_comb begin
    fire_ok  = fire && (refr_cnt == '0);
    refr_nxt = '0;
    if (fire_ok)
      refr_nxt = REFR_LOAD;
    else if (refr_cnt != '0)
      refr_nxt = refr_cnt - 1'b1;
    suppress = fire_ok || (refr_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_idx  <= '0;
      refr_cnt   <= '0;
      drop_count <= '0;
      acks_out   <= '0;
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      acc_en     <= 1'b0;
      acc_clear  <= 1'b0;
      spike_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      refr_cnt  <= refr_nxt;
      spike_out <= fire_ok;
      acc_clear <= fire_ok;
      rom_en    <= 1'b0;
      acc_en    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            rom_addr  <= arb_idx;
            rom_en    <= 1'b1;
            acc_en    <= !suppress;
            acks_out  <= N_IN'(1) << arb_idx;
            busy      <= 1'b1;
            state     <= ISSUE;
            if (suppress && drop_count != CNT_MAX)
              drop_count <= drop_count + 1'b1;
          end
        end
        ISSUE: state <= RELEASE;
        RELEASE: begin
          if (!spikes_in[grant_idx]) begin
            acks_out <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
            ptr <= (grant_idx == LAST_IDX) ? '0
                   : grant_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Scoreboard bench: a per-edge reference model predicts every
// output cycle; a monitor compares them against the DUT.
module tb_spike_event_scheduler;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int RF = 5;
  localparam int CW = 4;
  localparam int AGE_MAX = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fire;
  logic [N-1:0]  spikes_in;
  logic [N-1:0]  acks_out;
  logic [AW-1:0] rom_addr;
  logic          rom_en, acc_en, acc_clear, spike_out, busy;
  logic [CW-1:0] drop_count;

  always #5 clk = ~clk;

  spike_event_scheduler #(
    .N_IN(N), .ADDR_W(AW), .REFRACTORY(RF), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spikes_in  (spikes_in),
    .acks_out   (acks_out),
    .fire       (fire),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .acc_en     (acc_en),
    .acc_clear  (acc_clear),
    .spike_out  (spike_out),
    .busy       (busy),
    .drop_count (drop_count)
  );

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [AW-1:0] addr;
    logic          ren;
    logic          aen;
    logic          clr;
    logic          spk;
    logic          bsy;
    logic [CW-1:0] drp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: which line is being served, where the
  // rotation resumes, cycles of refractory left, drops so far.
  int m_line, m_ptr, m_refr, m_drop, m_addr;
  bit m_fresh;
  int age[N];
  int max_age = 0;
  logic [N-1:0] hold = '0;

  function automatic exp_t model_step(logic [N-1:0] req,
                                      logic f, logic rst);
    exp_t e;
    bit fired;
    int i;
    e = '0;
    if (rst) begin
      m_line = -1; m_ptr = 0; m_refr = 0;
      m_drop = 0; m_addr = 0; m_fresh = 0;
      return e;
    end
    fired = f && (m_refr == 0);
    if (fired) m_refr = RF;
    else if (m_refr > 0) m_refr = m_refr - 1;
    e.clr = fired;
    e.spk = fired;
    if (m_line < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (req[i]) begin
          m_line = i;
          break;
        end
      end
      if (m_line >= 0) begin
        m_fresh = 1;
        m_addr = m_line;
        e.ren = 1'b1;
        e.aen = !(fired || m_refr > 0);
        if (!e.aen && m_drop < (1 << CW) - 1)
          m_drop = m_drop + 1;
      end
    end else if (m_fresh) begin
      m_fresh = 0;
    end else if (!req[m_line]) begin
      m_ptr = (m_line + 1) % N;
      m_line = -1;
    end
    if (m_line >= 0) begin
      e.ack = N'(1) << m_line;
      e.bsy = 1'b1;
    end
    e.addr = AW'(m_addr);
    e.drp = CW'(m_drop);
    return e;
  endfunction

  task automatic cycle(input logic [N-1:0] raise, input int rp,
                       input int fp, input int wp, input int sp);
    logic [N-1:0] r;
    logic f, rst;
    @(negedge clk);
    r = spikes_in;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        if (acks_out[i] && !hold[i]) r[i] = 1'b0;
        else if (!acks_out[i] && $urandom_range(99) < wp)
          r[i] = 1'b0;
      end else if (raise[i] && !acks_out[i] &&
                   $urandom_range(99) < rp) begin
        r[i] = 1'b1;
      end
    end
    f = ($urandom_range(99) < fp);
    rst = ($urandom_range(99) < sp);
    for (int i = 0; i < N; i++) begin
      if (rst || !spikes_in[i] || acks_out[i]) age[i] = 0;
      else age[i] = age[i] + 1;
      if (age[i] > max_age) max_age = age[i];
    end
    spikes_in = r;
    fire = f;
    resetn = rst;
    q.push_back(model_step(r, f, rst));
  endtask

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g.ack = acks_out; g.addr = rom_addr; g.ren = rom_en;
      g.aen = acc_en; g.clr = acc_clear; g.spk = spike_out;
      g.bsy = busy; g.drp = drop_count;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got ack=%h addr=%0d ren=%b aen=%b clr=%b spk=%b busy=%b drop=%0d want ack=%h addr=%0d ren=%b aen=%b clr=%b spk=%b busy=%b drop=%0d",
                 $time, g.ack, g.addr, g.ren, g.aen, g.clr, g.spk,
                 g.bsy, g.drp, e.ack, e.addr, e.ren, e.aen, e.clr,
                 e.spk, e.bsy, e.drp);
      end
    end
  end

  initial begin
    spikes_in = '0;
    fire = 1'b0;
    resetn = 1'b1;
    q.push_back(model_step('0, 1'b0, 1'b1));
    for (int i = 0; i < N; i++) age[i] = 0;
    cycle('0, 0, 0, 0, 100);
    cycle('0, 0, 0, 0, 0);
    // single request on line 2
    cycle(8'h04, 100, 0, 0, 0);
    repeat (6) cycle('0, 0, 0, 0, 0);
    // two lines contending continuously
    repeat (24) cycle(8'h81, 100, 0, 0, 0);
    repeat (4) cycle('0, 0, 0, 0, 0);
    // one fire then a stream of requests through refractory
    cycle('0, 0, 100, 0, 0);
    repeat (14) cycle(8'hFF, 100, 0, 0, 0);
    repeat (8) cycle('0, 0, 0, 0, 0);
    // fire sampled on the same edge as the grant
    cycle(8'h08, 100, 100, 0, 0);
    repeat (8) cycle('0, 0, 0, 0, 0);
    // reset while line 4 is held in its handshake
    hold = 8'h10;
    cycle(8'h10, 100, 0, 0, 0);
    repeat (3) cycle('0, 0, 0, 0, 0);
    cycle('0, 0, 0, 0, 100);
    repeat (4) cycle('0, 0, 0, 0, 0);
    hold = '0;
    repeat (6) cycle('0, 0, 0, 0, 0);
    // heavy firing to push the drop counter into saturation
    repeat (150) cycle(8'hFF, 100, 100, 0, 0);
    repeat (6) cycle('0, 0, 0, 0, 0);
    // mixed random traffic with withdrawals
    repeat (2000) cycle(8'hFF, 30, 8, 10, 0);
    repeat (500) cycle(8'hFF, 60, 3, 5, 1);
    repeat (10) cycle('0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (max_age > AGE_MAX) begin
      failures++;
      $display("FAIL starvation got max_wait=%0d want <=%0d",
               max_age, AGE_MAX);
    end
    checks++;
    if (drop_count !== CW'(m_drop)) begin
      failures++;
      $display("FAIL final_drop got %0d want %0d",
               drop_count, m_drop);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
